path_stack_unit: RTL and testbench
==================================

// Module: path_stack_unit
// PURPOSE
//   LIFO stack datapath that executes the push/pop/init commands issued by the
//   search Controller FSM during backtracking and reports status back to it.
//   It returns an 'updated' acknowledge once a command has completed and the
//   new top-of-stack is valid. It also drives 'done' when the stack has been
//   fully unwound.
// PARAMETERS
//   DATA_W  8   width of one stack entry (packed row/col coordinate)
//   ADDR_W  4   pointer width; DEPTH = 2**ADDR_W entries (default 16)
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   load_init  in   1        clear stack, then push init_data as entry 0
//   init_data  in   DATA_W   initial entry for load_init
//   push       in   1        push push_data
//   push_data  in   DATA_W   entry to push
//   poping     in   1        pop top entry
//   top_data   out  DATA_W   registered current top entry (0 when empty)
//   count      out  ADDR_W+1 number of valid entries, 0..DEPTH
//   updated    out  1        1-cycle ack: command finished, top_data/count valid
//   busy       out  1        command in progress; new commands ignored
//   done       out  1        level: count==0
//   full       out  1        level: count==DEPTH
//   overflow   out  1        sticky: push attempted while full
//   underflow  out  1        sticky: pop attempted while empty
// BEHAVIOUR
//   - Reset (sync, rst=1 at a rising edge): state=IDLE, count=0, top_data=0,
//     updated=0, busy=0, overflow=0, underflow=0. Memory contents are not
//     cleared. Reset overrides any command in flight, in any state.
//   - FSM states: IDLE -> EXEC -> FETCH -> ACK -> IDLE.
//     - IDLE: busy=0. Commands are sampled only here. Priority when more than
//       one is high: load_init > push > poping. Any command moves to EXEC.
//     - EXEC: busy=1. Applies the latched command:
//       - load_init: mem[0]<=init_data; count<=1. Clears overflow/underflow.
//       - push, not full: mem[count]<=push_data; count<=count+1.
//       - push, full: no write, count unchanged, overflow<=1.
//       - pop, count>0: count<=count-1.
//       - pop, count==0: count stays 0, underflow<=1.
//     - FETCH: busy=1. top_data<=(count==0) ? 0 : mem[count-1].
//     - ACK: busy=1, updated=1 for exactly one cycle. Next state is IDLE.
//   - Latency: a command sampled in IDLE at cycle t gives updated=1 in cycle
//     t+3, with top_data/count valid from t+3. The next command can be
//     accepted at t+4.
//   - Commands asserted while busy=1 are dropped, not queued. The requester
//     must hold or re-issue them.
//   - done, full and empty status are combinational from count. The error
//     flags and a failed command still complete with an updated pulse.
//   - No wrap-around. count saturates at 0 and at DEPTH.
//   - Memory is an array of DEPTH x DATA_W registers, written only in EXEC.
// TESTING
//   1. rst=1 for 2 cycles -> count=0, done=1, top_data=0, updated=0, busy=0.
//   2. load_init with init_data=8'h00, then push 8'h12, push 8'h25 ->
//      updated 3 cycles after each command; final count=3, top_data=8'h25.
//   3. From test 2, pop twice -> top_data 8'h12 then 8'h00. A third pop gives
//      count=0, done=1, top_data=0, underflow=0.
//   4. Push 16 entries 8'h01..8'h10, then push 8'hFF -> full=1, overflow=1,
//      count=16, top_data=8'h10, updated still pulses.
//   5. Assert push and poping together in IDLE -> push wins (count+1). Assert
//      poping during FETCH -> ignored, count unchanged.
//   6. Assert rst during EXEC of a push at count=5 -> next cycle: state=IDLE,
//      count=0, no updated pulse, flags cleared.

Source files
------------

// File: rtl/path_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : path_stack_unit
// Purpose  : LIFO stack datapath for the backtracking search controller.
//            It accepts one init, push or pop command at a time. When the
//            command has completed it gives a one-cycle 'updated' pulse with
//            a registered top-of-stack and entry count.
// Ports    : clk, rst             clock / synchronous active-high reset
//            load_init, init_data clear stack and seed entry 0
//            push, push_data      push one entry
//            poping               pop the top entry
//            top_data, count      registered top entry (0 when empty), depth
//            updated, busy        completion pulse, command in progress
//            done, full           count==0, count==DEPTH
//            overflow, underflow  sticky error flags (cleared by load_init)
// Revision : 1.0  initial release
// ============================================================================
module path_stack_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_init,
  input  logic [DATA_W-1:0] init_data,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              poping,
  output logic [DATA_W-1:0] top_data,
  output logic [ADDR_W:0]   count,
  output logic              updated,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, EXEC, FETCH, ACK} state_t;
  typedef enum logic [1:0] {CMD_INIT, CMD_PUSH, CMD_POP} cmd_t;

  state_t              state, state_next;
  cmd_t                cmd_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W:0]     count_m1;
  logic                any_cmd;

  assign any_cmd  = load_init | push | poping;
  assign count_m1 = count - ONE;

  assign done    = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign busy    = (state != IDLE);
  assign updated = (state == ACK);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: fixed four-step sequence once a command is accepted
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_cmd) state_next = EXEC;
      EXEC:    state_next = FETCH;
      FETCH:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latch, count, top-of-stack and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= CMD_POP;
      data_q    <= '0;
      count     <= '0;
      top_data  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Priority load_init > push > poping; commands are only seen here
          if (load_init) begin
            cmd_q  <= CMD_INIT;
            data_q <= init_data;
          end else if (push) begin
            cmd_q  <= CMD_PUSH;
            data_q <= push_data;
          end else if (poping) begin
            cmd_q  <= CMD_POP;
          end
        end
        EXEC: begin
          case (cmd_q)
            CMD_INIT: begin
              count     <= ONE;
              overflow  <= 1'b0;
              underflow <= 1'b0;
            end
            CMD_PUSH: begin
              if (full) overflow <= 1'b1;
              else      count    <= count + ONE;
            end
            default: begin
              if (done) underflow <= 1'b1;
              else      count     <= count_m1;
            end
          endcase
        end
        FETCH: begin
          top_data <= done ? '0 : mem[count_m1[ADDR_W-1:0]];
        end
        default: ;
      endcase
    end
  end

  // Storage is not reset; a reset arriving in EXEC suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && state == EXEC) begin
      if (cmd_q == CMD_INIT) begin
        mem[0] <= data_q;
      end else if (cmd_q == CMD_PUSH && !full) begin
        mem[count[ADDR_W-1:0]] <= data_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_path_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_path_stack_unit
// Purpose  : Directed self-checking bench for path_stack_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_path_stack_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_init;
  logic [7:0] init_data;
  logic       push;
  logic [7:0] push_data;
  logic       poping;
  logic [7:0] top_data;
  logic [4:0] count;
  logic       updated, busy, done, full, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  path_stack_unit #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_init (load_init),
    .init_data (init_data),
    .push      (push),
    .push_data (push_data),
    .poping    (poping),
    .top_data  (top_data),
    .count     (count),
    .updated   (updated),
    .busy      (busy),
    .done      (done),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command in IDLE, measure cycles to 'updated' and return in IDLE.
  task automatic do_cmd(input logic li, input logic ps, input logic pp, input logic [7:0] d);
    int lat;
    load_init = li; push = ps; poping = pp;
    init_data = d;  push_data = d;
    @(posedge clk); #1;
    load_init = 1'b0; push = 1'b0; poping = 1'b0;
    lat = 1;
    while (!updated && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 3);
    check("busy_in_ack", 32'(busy), 1);
    @(posedge clk); #1;
    check("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; load_init = 1'b0; push = 1'b0; poping = 1'b0;
    init_data = '0; push_data = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_count",   32'(count), 0);
    check("rst_done",    32'(done), 1);
    check("rst_top",     32'(top_data), 0);
    check("rst_updated", 32'(updated), 0);
    check("rst_busy",    32'(busy), 0);
    check("rst_ovf",     32'(overflow), 0);
    check("rst_udf",     32'(underflow), 0);

    // Init and two pushes
    do_cmd(1, 0, 0, 8'h00);
    check("init_count", 32'(count), 1);
    check("init_top",   32'(top_data), 'h00);
    do_cmd(0, 1, 0, 8'h12);
    check("push1_top",  32'(top_data), 'h12);
    do_cmd(0, 1, 0, 8'h25);
    check("push2_count", 32'(count), 3);
    check("push2_top",   32'(top_data), 'h25);

    // Unwind
    do_cmd(0, 0, 1, 8'h00);
    check("pop1_count", 32'(count), 2);
    check("pop1_top",   32'(top_data), 'h12);
    do_cmd(0, 0, 1, 8'h00);
    check("pop2_count", 32'(count), 1);
    check("pop2_top",   32'(top_data), 'h00);
    do_cmd(0, 0, 1, 8'h00);
    check("pop3_count", 32'(count), 0);
    check("pop3_done",  32'(done), 1);
    check("pop3_top",   32'(top_data), 0);
    check("pop3_udf",   32'(underflow), 0);
    do_cmd(0, 0, 1, 8'h00);
    check("pop4_count", 32'(count), 0);
    check("pop4_udf",   32'(underflow), 1);

    // Fill to the top and overflow
    for (int i = 1; i <= 16; i++) begin
      do_cmd(0, 1, 0, 8'(i));
      check("fill_count", 32'(count), i);
      check("fill_top",   32'(top_data), i);
    end
    check("fill_full", 32'(full), 1);
    check("fill_ovf",  32'(overflow), 0);
    do_cmd(0, 1, 0, 8'hFF);
    check("ovf_full",  32'(full), 1);
    check("ovf_flag",  32'(overflow), 1);
    check("ovf_count", 32'(count), 16);
    check("ovf_top",   32'(top_data), 'h10);

    // Pop back down to five entries; entry k holds k+1
    for (int c = 15; c >= 5; c--) begin
      do_cmd(0, 0, 1, 8'h00);
      check("down_count", 32'(count), c);
      check("down_top",   32'(top_data), c);
    end
    check("down_full", 32'(full), 0);
    check("down_ovf",  32'(overflow), 1);

    // Reset during EXEC of a push at count 5
    push = 1'b1; push_data = 8'hAA;
    @(posedge clk); #1;
    push = 1'b0;
    check("exec_busy", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_ovf",   32'(overflow), 0);
    check("mid_rst_udf",   32'(underflow), 0);
    check("mid_rst_top",   32'(top_data), 0);
    for (int i = 0; i < 4; i++) begin
      check("mid_rst_no_upd", 32'(updated), 0);
      @(posedge clk); #1;
    end

    // Push beats pop when both asserted
    do_cmd(1, 0, 0, 8'h33);
    check("init2_top", 32'(top_data), 'h33);
    do_cmd(0, 1, 1, 8'h44);
    check("both_count", 32'(count), 2);
    check("both_top",   32'(top_data), 'h44);

    // Pop asserted during FETCH is dropped
    push = 1'b1; push_data = 8'h55;
    @(posedge clk); #1;          // EXEC
    push = 1'b0;
    @(posedge clk); #1;          // FETCH
    poping = 1'b1;
    @(posedge clk); #1;          // ACK
    poping = 1'b0;
    check("fp_updated", 32'(updated), 1);
    @(posedge clk); #1;          // IDLE
    check("fp_busy",  32'(busy), 0);
    check("fp_count", 32'(count), 3);
    check("fp_top",   32'(top_data), 'h55);
    repeat (4) @(posedge clk);
    #1;
    check("fp_count_later", 32'(count), 3);
    check("fp_busy_later",  32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
